// File: rtl/vga_capture_if.sv
// Framebuffer write port of the VGA capture block.
// wr_en qualifies wr_x/wr_y/wr_rgb for exactly one cycle; there is no ready, so the sink must accept every strobe.
interface vga_capture_if;
  logic       wr_en;
  logic [9:0] wr_x;
  logic [8:0] wr_y;
  logic [2:0] wr_rgb;
  logic       frame_done;

  modport master (output wr_en, wr_x, wr_y, wr_rgb, frame_done);
  modport slave  (input  wr_en, wr_x, wr_y, wr_rgb, frame_done);
endinterface

// File: rtl/vga_capture.sv
// Locks onto an incoming VGA timing, measures its resolution and writes a fixed
// window of each frame to a framebuffer once lock is stable and capture is requested.
module vga_capture #(
  parameter int H_START = 16,
  parameter int V_START = 2,
  parameter int ACT_W   = 512,
  parameter int ACT_H   = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vga_h_sync,
  input  logic          vga_v_sync,
  input  logic          R,
  input  logic          G,
  input  logic          B,
  input  logic          capture_en,
  vga_capture_if.master wr,
  output logic [9:0]    res_x,
  output logic [8:0]    res_y,
  output logic          locked,
  output logic [7:0]    lock_loss_cnt,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  localparam logic [10:0] X_LO = 11'(H_START);
  localparam logic [10:0] X_HI = 11'(H_START + ACT_W);
  localparam logic [9:0]  Y_LO = 10'(V_START);
  localparam logic [9:0]  Y_HI = 10'(V_START + ACT_H);

  state_t     state_q, state_d;
  logic       hs1, vs1, hs1_d, vs1_d;
  logic [2:0] rgb1;
  logic       hfall, vfall;
  logic [9:0] x_q, x_cur, ref_x;
  logic [8:0] y_q, y_cur, ref_y;
  logic       x_sat, y_sat, line_bad, frame_bad;
  logic       got_x_q, mismatch_q, capture_q, capture_d, in_win;
  logic       clr_meas, ld_ref_x, ld_ref_y, set_mis, ld_res, lose_lock;

  // Stage 1: sync registers idle high so reset never manufactures a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs1   <= 1'b1;
      vs1   <= 1'b1;
      hs1_d <= 1'b1;
      vs1_d <= 1'b1;
      rgb1  <= 3'd0;
    end else begin
      hs1   <= vga_h_sync;
      vs1   <= vga_v_sync;
      hs1_d <= hs1;
      vs1_d <= vs1;
      rgb1  <= {R, G, B};
    end
  end

  assign hfall = hs1_d & ~hs1;
  assign vfall = vs1_d & ~vs1;

  // x_q/y_q hold the position of the previous sample, which is also the line/frame candidate.
  always_comb begin
    x_cur = hfall ? 10'd0 : ((x_q == 10'h3FF) ? x_q : x_q + 10'd1);
    y_cur = y_q;
    if (vfall)      y_cur = 9'd0;
    else if (hfall) y_cur = (y_q == 9'h1FF) ? y_q : y_q + 9'd1;
  end

  assign x_sat     = (x_cur == 10'h3FF);
  assign y_sat     = (y_cur == 9'h1FF);
  assign line_bad  = hfall && (x_q != ref_x);
  assign frame_bad = vfall && (y_q != ref_y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SEARCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    clr_meas = 1'b0;
    ld_ref_x = 1'b0;
    ld_ref_y = 1'b0;
    set_mis  = 1'b0;
    ld_res   = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (vfall) begin
          state_d  = MEASURE;
          clr_meas = 1'b1;
        end
      end
      MEASURE: begin
        if (vfall) begin
          if (mismatch_q || !got_x_q || line_bad) begin
            state_d = SEARCH;
          end else begin
            state_d  = VERIFY;
            ld_ref_y = 1'b1;
          end
        end else if (hfall) begin
          if (!got_x_q)     ld_ref_x = 1'b1;
          else if (line_bad) set_mis = 1'b1;
        end
      end
      VERIFY: begin
        if (line_bad || frame_bad || x_sat || y_sat) begin
          state_d = SEARCH;
        end else if (vfall) begin
          state_d = LOCKED;
          ld_res  = 1'b1;
        end
      end
      LOCKED: begin
        if (line_bad || frame_bad || x_sat || y_sat) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
  end

  assign lose_lock = (state_q == LOCKED) && (state_d != LOCKED);
  // Capture only ever runs in LOCKED; the locking VFALL itself may arm it.
  assign capture_d = (state_d == LOCKED) && (vfall ? capture_en : capture_q);
  assign in_win    = capture_q && (state_d == LOCKED)
                     && ({1'b0, x_cur} >= X_LO) && ({1'b0, x_cur} < X_HI)
                     && ({1'b0, y_cur} >= Y_LO) && ({1'b0, y_cur} < Y_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q           <= 10'd0;
      y_q           <= 9'd0;
      ref_x         <= 10'd0;
      ref_y         <= 9'd0;
      res_x         <= 10'd0;
      res_y         <= 9'd0;
      got_x_q       <= 1'b0;
      mismatch_q    <= 1'b0;
      capture_q     <= 1'b0;
      lock_loss_cnt <= 8'd0;
    end else begin
      x_q       <= x_cur;
      y_q       <= y_cur;
      capture_q <= capture_d;
      if (clr_meas) begin
        got_x_q    <= 1'b0;
        mismatch_q <= 1'b0;
      end
      if (ld_ref_x) begin
        ref_x   <= x_q;
        got_x_q <= 1'b1;
      end
      if (set_mis)  mismatch_q <= 1'b1;
      if (ld_ref_y) ref_y <= y_q;
      if (ld_res) begin
        res_x <= ref_x;
        res_y <= ref_y;
      end
      if (lose_lock && lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end

  // Stage 2: write port, two cycles behind the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr.wr_en      <= 1'b0;
      wr.wr_x       <= 10'd0;
      wr.wr_y       <= 9'd0;
      wr.wr_rgb     <= 3'd0;
      wr.frame_done <= 1'b0;
    end else begin
      wr.wr_en      <= in_win;
      wr.wr_x       <= x_cur - X_LO[9:0];
      wr.wr_y       <= y_cur - Y_LO[8:0];
      wr.wr_rgb     <= rgb1;
      wr.frame_done <= vfall && capture_q;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture: scaled-down timing (40x10 and 10x2 frames, 8x4 window)
// keeps every scenario short while exercising the same counters and FSM paths.
module tb_vga_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hs = 1'b1, vs = 1'b1, r = 1'b0, g = 1'b0, b = 1'b0, cap_en = 1'b0;
  logic [9:0] res_x;
  logic [8:0] res_y;
  logic       locked;
  logic [7:0] llc;
  logic [1:0] dbg_state;

  vga_capture_if wif();

  vga_capture #(.H_START(16), .V_START(2), .ACT_W(8), .ACT_H(4)) dut (
    .clk(clk), .rst(rst), .vga_h_sync(hs), .vga_v_sync(vs),
    .R(r), .G(g), .B(b), .capture_en(cap_en), .wr(wif),
    .res_x(res_x), .res_y(res_y), .locked(locked),
    .lock_loss_cnt(llc), .dbg_state(dbg_state)
  );

  // Clock / reset-independent bookkeeping
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [21:0] got_q[$];
  int          got_cyc_q[$];
  logic [21:0] exp_q[$];
  int          fd_cnt = 0, fd_cyc = -1, lock_rise_cyc = -1, lock_fall_cyc = -1;
  logic        locked_prev = 1'b0;
  int          frame_start_cyc, px_cyc, glitch_cyc;

  // Monitor: collects writes and event times at the falling edge.
  always @(negedge clk) begin
    if (wif.wr_en) begin
      got_q.push_back({wif.wr_x, wif.wr_y, wif.wr_rgb});
      got_cyc_q.push_back(cyc);
    end
    if (wif.frame_done) begin
      fd_cnt <= fd_cnt + 1;
      fd_cyc <= cyc;
    end
    if (locked && !locked_prev) lock_rise_cyc <= cyc;
    if (!locked && locked_prev) lock_fall_cyc <= cyc;
    locked_prev <= locked;
  end

  function automatic logic [2:0] pix_rgb(input int x, input int y);
    int v;
    v = x + 2 * y + 1;
    return v[2:0];
  endfunction

  // Driver: one frame, h-sync and v-sync fall together at line 0 column 0.
  task automatic gen_frame(input int period, input int lines, input int bad_line,
                           input int bad_period, input int cap_off_line);
    int per, hsw;
    logic [2:0] c;
    hsw = (period > 20) ? 4 : 2;
    for (int l = 0; l < lines; l++) begin
      per = (l == bad_line) ? bad_period : period;
      for (int x = 0; x < per; x++) begin
        @(negedge clk);
        if (l == cap_off_line && x == 0) cap_en = 1'b0;
        hs = (x < hsw) ? 1'b0 : 1'b1;
        vs = (l == 0) ? 1'b0 : 1'b1;
        c = pix_rgb(x, l);
        {r, g, b} = c;
        if (l == 0 && x == 0)  frame_start_cyc = cyc;
        if (l == 2 && x == 16) px_cyc = cyc;
        if (l == bad_line + 1 && x == 0) glitch_cyc = cyc;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cap_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wif.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wif.wr_en); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
    checks++; if (wif.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", wif.frame_done); end
    checks++; if (res_x !== 10'd0) begin errors++; $display("FAIL reset_res_x: got %0d want 0", res_x); end
    checks++; if (res_y !== 9'd0) begin errors++; $display("FAIL reset_res_y: got %0d want 0", res_y); end
    checks++; if (llc !== 8'd0) begin errors++; $display("FAIL reset_loss_cnt: got %0d want 0", llc); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lock_and_capture;
    int s3, p, base;
    logic [21:0] gv;
    cap_en = 1'b1;
    got_q.delete();
    got_cyc_q.delete();
    base = fd_cnt;
    gen_frame(40, 10, -1, 0, -1);
    gen_frame(40, 10, -1, 0, -1);
    gen_frame(40, 10, -1, 0, -1);
    s3 = frame_start_cyc;
    p  = px_cyc;
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_locked: got %b want 1", locked); end
    checks++; if (res_x !== 10'd39) begin errors++; $display("FAIL lock_res_x: got %0d want 39", res_x); end
    checks++; if (res_y !== 9'd9) begin errors++; $display("FAIL lock_res_y: got %0d want 9", res_y); end
    checks++; if (lock_rise_cyc !== s3 + 2) begin errors++; $display("FAIL lock_rise_time: got %0d want %0d", lock_rise_cyc, s3 + 2); end
    exp_q.delete();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++)
        exp_q.push_back({10'(x), 9'(y), pix_rgb(x + 16, y + 2)});
    checks++; if (got_q.size() !== 32) begin errors++; $display("FAIL cap_count: got %0d want 32", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      gv = (i < got_q.size()) ? got_q[i] : 'x;
      checks++; if (gv !== exp_q[i]) begin errors++; $display("FAIL cap_data[%0d]: got %h want %h", i, gv, exp_q[i]); end
    end
    checks++; if (got_q.size() == 0 || got_q[0] !== {10'd0, 9'd0, 3'b101}) begin errors++; $display("FAIL first_pixel: got %h want %h", (got_q.size() > 0) ? got_q[0] : 22'h0, {10'd0, 9'd0, 3'b101}); end
    checks++; if (got_cyc_q.size() == 0 || got_cyc_q[0] !== p + 2) begin errors++; $display("FAIL pixel_latency: got cycle %0d want %0d", (got_cyc_q.size() > 0) ? got_cyc_q[0] : -1, p + 2); end
    gen_frame(40, 10, -1, 0, -1);
    checks++; if (fd_cnt - base !== 1) begin errors++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt - base); end
    checks++; if (fd_cyc !== frame_start_cyc + 2) begin errors++; $display("FAIL frame_done_time: got %0d want %0d", fd_cyc, frame_start_cyc + 2); end
  endtask

  task automatic test_line_glitch;
    int gc;
    got_q.delete();
    gen_frame(40, 10, 3, 41, -1);
    gc = glitch_cyc;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL glitch_locked: got %b want 0", locked); end
    checks++; if (lock_fall_cyc !== gc + 2) begin errors++; $display("FAIL glitch_fall_time: got %0d want %0d", lock_fall_cyc, gc + 2); end
    checks++; if (llc !== 8'd1) begin errors++; $display("FAIL glitch_loss_cnt: got %0d want 1", llc); end
    checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL glitch_writes: got %0d want 16", got_q.size()); end
    checks++; if (res_x !== 10'd39) begin errors++; $display("FAIL glitch_res_hold: got %0d want 39", res_x); end
    got_q.delete();
    gen_frame(40, 10, -1, 0, -1);
    gen_frame(40, 10, -1, 0, -1);
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL relock_no_writes: got %0d want 0", got_q.size()); end
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL relock_verify: got %0d want 2", dbg_state); end
    gen_frame(40, 10, -1, 0, -1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock_locked: got %b want 1", locked); end
  endtask

  task automatic test_capture_disable;
    int base;
    base = fd_cnt;
    got_q.delete();
    gen_frame(40, 10, -1, 0, 4);
    checks++; if (got_q.size() !== 32) begin errors++; $display("FAIL capoff_writes: got %0d want 32", got_q.size()); end
    checks++; if (got_q.size() == 0 || got_q[got_q.size() - 1] !== {10'd7, 9'd3, pix_rgb(23, 5)}) begin errors++; $display("FAIL capoff_last: got %h want %h", (got_q.size() > 0) ? got_q[got_q.size() - 1] : 22'h0, {10'd7, 9'd3, pix_rgb(23, 5)}); end
    got_q.delete();
    gen_frame(40, 10, -1, 0, -1);
    gen_frame(40, 10, -1, 0, -1);
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL capoff_idle: got %0d want 0", got_q.size()); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL capoff_locked: got %b want 1", locked); end
    checks++; if (fd_cnt - base !== 2) begin errors++; $display("FAIL capoff_frame_done: got %0d want 2", fd_cnt - base); end
  endtask

  task automatic test_same_sample;
    cap_en = 1'b1;
    got_q.delete();
    gen_frame(40, 10, -1, 0, -1);
    checks++; if (got_q.size() !== 32) begin errors++; $display("FAIL same_writes: got %0d want 32", got_q.size()); end
    checks++; if (got_q.size() < 32 || got_q[0] !== {10'd0, 9'd0, pix_rgb(16, 2)}) begin errors++; $display("FAIL same_row0: got %h want %h", (got_q.size() > 0) ? got_q[0] : 22'h0, {10'd0, 9'd0, pix_rgb(16, 2)}); end
    checks++; if (got_q.size() < 32 || got_q[8] !== {10'd0, 9'd1, pix_rgb(16, 3)}) begin errors++; $display("FAIL same_row1: got %h want %h", (got_q.size() > 8) ? got_q[8] : 22'h0, {10'd0, 9'd1, pix_rgb(16, 3)}); end
    checks++; if (res_y !== 9'd9) begin errors++; $display("FAIL same_res_y: got %0d want 9", res_y); end
    checks++; if (llc !== 8'd1) begin errors++; $display("FAIL same_loss_cnt: got %0d want 1", llc); end
  endtask

  task automatic test_reset_mid;
    fork
      gen_frame(40, 10, -1, 0, -1);
      begin
        for (int i = 0; i < 2000 && wif.wr_en !== 1'b1; i++) @(negedge clk);
        checks++; if (wif.wr_en !== 1'b1) begin errors++; $display("FAIL rstmid_capturing: got %b want 1", wif.wr_en); end
        #2 rst = 1'b1;
        #1;
        checks++; if (wif.wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr_en: got %b want 0", wif.wr_en); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rstmid_locked: got %b want 0", locked); end
        checks++; if (llc !== 8'd0) begin errors++; $display("FAIL rstmid_loss_cnt: got %0d want 0", llc); end
        checks++; if (res_x !== 10'd0) begin errors++; $display("FAIL rstmid_res_x: got %0d want 0", res_x); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    got_q.delete();
    gen_frame(40, 10, -1, 0, -1);
    gen_frame(40, 10, -1, 0, -1);
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL rstmid_no_writes: got %0d want 0", got_q.size()); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rstmid_unlocked: got %b want 0", locked); end
    gen_frame(40, 10, -1, 0, -1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rstmid_relock: got %b want 1", locked); end
    checks++; if (res_x !== 10'd39) begin errors++; $display("FAIL rstmid_res_x_relock: got %0d want 39", res_x); end
  endtask

  task automatic test_lock_loss_sat;
    cap_en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      gen_frame(10, 2, 0, 11, -1);
      repeat (3) gen_frame(10, 2, -1, 0, -1);
      if (i == 0) begin
        checks++; if (llc !== 8'd1) begin errors++; $display("FAIL sat_first_loss: got %0d want 1", llc); end
      end
    end
    checks++; if (llc !== 8'd255) begin errors++; $display("FAIL sat_loss_cnt: got %0d want 255", llc); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_locked: got %b want 1", locked); end
    checks++; if (res_x !== 10'd9) begin errors++; $display("FAIL sat_res_x: got %0d want 9", res_x); end
    checks++; if (res_y !== 9'd1) begin errors++; $display("FAIL sat_res_y: got %0d want 1", res_y); end
  endtask

  initial begin
    test_reset();
    test_lock_and_capture();
    test_line_glitch();
    test_capture_disable();
    test_same_sample();
    test_reset_mid();
    test_lock_loss_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter H_START, default 16, first captured sample of a line, counted from the h-sync falling edge.
REQ-002 Parameter V_START, default 2, first captured line of a frame, counted from the v-sync falling edge.
REQ-003 Parameter ACT_W, default 512, captured pixels per line.
REQ-004 Parameter ACT_H, default 256, captured lines per frame.
REQ-005 Port clk  in  1  pixel clock; all inputs are synchronous to it.
REQ-006 Port rst  in  1  asynchronous, active-high reset.
REQ-007 Port vga_h_sync  in  1  horizontal sync, active-low.
REQ-008 Port vga_v_sync  in  1  vertical sync, active-low.
REQ-009 Ports R, G, B  in  1 each  pixel colour bits.
REQ-010 Port capture_en  in  1  request to capture frames; sampled only at a v-sync falling edge.
REQ-011 Port wr_en  out  1  framebuffer write strobe.
REQ-012 Port wr_x  out  10  captured pixel column, 0..ACT_W-1.
REQ-013 Port wr_y  out  9  captured pixel row, 0..ACT_H-1.
REQ-014 Port wr_rgb  out  3  {R,G,B} of the captured pixel.
REQ-015 Port res_x  out  10  measured line period minus 1.
REQ-016 Port res_y  out  9  measured lines per frame minus 1.
REQ-017 Port locked  out  1  timing stable; high only in LOCKED.
REQ-018 Port frame_done  out  1  one-cycle pulse at the end of each captured frame.
REQ-019 Port lock_loss_cnt  out  8  count of LOCKED->SEARCH transitions, saturating.

Function
REQ-020 Stage 1 SHALL register vga_h_sync, vga_v_sync and R, G, B; edge detection compares the stage-1 value with the previous stage-1 value.
REQ-021 HFALL = stage-1 h-sync goes 1->0; VFALL = stage-1 v-sync goes 1->0.
REQ-022 The x counter SHALL load 0 on HFALL, otherwise increment, saturating at 1023.
REQ-023 The y counter SHALL load 0 on VFALL, including when HFALL occurs in the same cycle.
REQ-024 On HFALL without VFALL, the y counter SHALL increment, saturating at 511.
REQ-025 On HFALL, the line period candidate SHALL equal the x value of the preceding sample.
REQ-026 On VFALL, the frame candidate SHALL equal the y value of the preceding sample.
REQ-027 FSM states: SEARCH, MEASURE, VERIFY, LOCKED.
REQ-028 SEARCH -> MEASURE on VFALL.
REQ-029 MEASURE: the first line candidate of the frame SHALL be stored as ref_x; any later line candidate in the same frame that differs from ref_x SHALL set a mismatch flag.
REQ-030 MEASURE, at the next VFALL: without mismatch, store ref_y and go to VERIFY; with mismatch, go to SEARCH.
REQ-031 VERIFY, at the next VFALL: if no line mismatched ref_x and the frame candidate equals ref_y, go to LOCKED, load res_x=ref_x and res_y=ref_y, and assert locked from the next cycle; otherwise go to SEARCH.
REQ-032 VERIFY and LOCKED: any line candidate differing from ref_x, any frame candidate differing from ref_y, or a saturated x or y counter SHALL force SEARCH on the next cycle.
REQ-033 On LOCKED->SEARCH, locked SHALL drop the next cycle and lock_loss_cnt SHALL increment, holding at 255; res_x and res_y SHALL hold their last values.
REQ-034 The capture flag SHALL be set on VFALL while in LOCKED with capture_en=1, and cleared on VFALL with capture_en=0 or on leaving LOCKED.
REQ-035 Capture window: capture flag set and H_START <= x < H_START+ACT_W and V_START <= y < V_START+ACT_H.
REQ-036 Stage 2 SHALL register wr_en = in-window, wr_x = x-H_START, wr_y = y-V_START, wr_rgb = stage-1 {R,G,B}; latency from pins to write port is 2 cycles.
REQ-037 frame_done SHALL pulse for one cycle on the VFALL that ends a frame with the capture flag set, in the same stage-2 cycle as the last wr_en of that frame's timing.
REQ-038 Lines shorter than H_START+ACT_W or frames shorter than V_START+ACT_H SHALL produce only the in-window writes that occur, with no error.

Reset
REQ-039 While rst=1: FSM=SEARCH; counters, ref_x, ref_y, res_x, res_y, lock_loss_cnt = 0; wr_en, locked, frame_done, capture flag = 0; synchronizer registers = 1 (sync idle).
REQ-040 Reset asserted mid-frame SHALL drop wr_en and locked asynchronously; after release, no write SHALL occur before a new lock.

Verification
REQ-041 Source with line period 800 and 525 lines, capture_en=1 -> res_x=799, res_y=524, locked rises 1 cycle after the third VFALL; the following frame gives 512x256 writes, then frame_done.
REQ-042 Drive pixel column 16 on line 2 with {R,G,B}=3'b101 -> wr_en with wr_x=0, wr_y=0, wr_rgb=3'b101, 2 cycles after the pins.
REQ-043 While locked, a single line of period 801 -> locked=0 the next cycle, lock_loss_cnt=1, wr_en=0, relock after 3 further VFALLs.
REQ-044 capture_en dropped mid-frame -> writes continue to the end of the frame; none in the next frame; locked stays 1.
REQ-045 HFALL and VFALL in the same sample -> y=0, res_y unchanged while stable, no spurious y=1.
REQ-046 rst pulsed mid-capture -> all outputs 0 immediately; 300 lock losses -> lock_loss_cnt holds 255.
